lfsr_seq_ctrl: RTL and testbench

Two-requester controller that shares a single `lfsr_1` datapath instance. It round-robin arbitrates seed/step-count jobs, loads the seed, and advances the LFSR exactly the requested number of steps. It then captures the result and returns it to the winning requester with a one-cycle completion pulse. It sits between the `lfsr_1` instance and its consumers and is the only block that drives the LFSR's `rst_i`, `val` and `start_i`.

---
 rtl/lfsr_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: two-requester round-robin job controller for a shared LFSR.
// It latches a seed and step count per job, loads the LFSR, advances it for
// the requested number of steps, then returns the captured result to the owner.
// Optional feature macro: LFSR_SEQ_CTRL_MATCH_EN adds match_o, which flags a
// result equal to the job's seed and is used for period checks.
module lfsr_seq_ctrl #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      req_i,
  input  logic [2*W-1:0]  seed_i,
  input  logic [2*CW-1:0] steps_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      done_o,
  output logic [W-1:0]    data_o,
  output logic            busy_o,
  output logic            lfsr_rst_o,
  output logic [W-1:0]    lfsr_val_o,
  output logic            lfsr_start_o,
`ifdef LFSR_SEQ_CTRL_MATCH_EN
  output logic            match_o,
`endif
  input  logic [W-1:0]    lfsr_result_i
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    seed_q, seed_d;
  logic [CW-1:0]   steps_q, steps_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [W-1:0]    data_q, data_d;
  logic            lrst_q, lrst_d;
  logic            arb_last;
  logic            win;
`ifdef LFSR_SEQ_CTRL_MATCH_EN
  logic            match_q, match_d;
`endif

  // Round-robin pick: on contention the side not served last wins; a lone
  // request wins outright. In DONE the finishing owner counts as last served
  // so that a back-to-back grant already sees the updated pointer.
  always_comb begin
    arb_last = (state_q == DONE) ? owner_q : last_q;
    if (req_i == 2'b11) win = ~arb_last;
    else                win = req_i[1];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    data_d  = data_q;
`ifdef LFSR_SEQ_CTRL_MATCH_EN
    match_d = match_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d      = LOAD;
          owner_d      = win;
          gnt_d[win]   = 1'b1;
          seed_d       = win ? seed_i[W +: W]    : seed_i[0 +: W];
          steps_d      = win ? steps_i[CW +: CW] : steps_i[0 +: CW];
        end
      end
      LOAD: begin
        cnt_d   = steps_q;
        state_d = (steps_q == '0) ? DONE : RUN;
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        done_d[owner_q] = 1'b1;
        data_d          = lfsr_result_i;
`ifdef LFSR_SEQ_CTRL_MATCH_EN
        match_d         = (lfsr_result_i == seed_q);
`endif
        last_d          = owner_q;
        if (|req_i) begin
          state_d    = LOAD;
          owner_d    = win;
          gnt_d[win] = 1'b1;
          seed_d     = win ? seed_i[W +: W]    : seed_i[0 +: W];
          steps_d    = win ? steps_i[CW +: CW] : steps_i[0 +: CW];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    lrst_d = (state_d == LOAD);
  end

  // State and output registers; reset holds the LFSR in its own reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      seed_q  <= '0;
      steps_q <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      data_q  <= '0;
      lrst_q  <= 1'b1;
`ifdef LFSR_SEQ_CTRL_MATCH_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      data_q  <= data_d;
      lrst_q  <= lrst_d;
`ifdef LFSR_SEQ_CTRL_MATCH_EN
      match_q <= match_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign data_o       = data_q;
  assign busy_o       = (state_q != IDLE);
  assign lfsr_rst_o   = lrst_q;
  assign lfsr_val_o   = seed_q;
  assign lfsr_start_o = (state_q == RUN);
`ifdef LFSR_SEQ_CTRL_MATCH_EN
  assign match_o      = match_q;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural 8-bit LFSR on the datapath
// side (x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0).
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [15:0] seed_i;
  logic [15:0] steps_i;
  logic [1:0]  gnt_o;
  logic [1:0]  done_o;
  logic [7:0]  data_o;
  logic        busy_o;
  logic        lfsr_rst_o;
  logic [7:0]  lfsr_val_o;
  logic        lfsr_start_o;
  logic [7:0]  lq;
  logic        match_w;
`ifdef LFSR_SEQ_CTRL_MATCH_EN
  logic        match_o;
  assign match_w = match_o;
`else
  assign match_w = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.W(8), .CW(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .seed_i(seed_i), .steps_i(steps_i),
    .gnt_o(gnt_o), .done_o(done_o), .data_o(data_o), .busy_o(busy_o),
    .lfsr_rst_o(lfsr_rst_o), .lfsr_val_o(lfsr_val_o), .lfsr_start_o(lfsr_start_o),
`ifdef LFSR_SEQ_CTRL_MATCH_EN
    .match_o(match_o),
`endif
    .lfsr_result_i(lq)
  );

  function automatic logic [7:0] lstep(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [7:0] lref(input logic [7:0] s, input int n);
    logic [7:0] q;
    q = s;
    for (int i = 0; i < n; i++) q = lstep(q);
    return q;
  endfunction

  // Stand-in for the shared lfsr_1 datapath.
  always @(posedge clk) begin
    if (lfsr_rst_o)        lq <= lfsr_val_o;
    else if (lfsr_start_o) lq <= lstep(lq);
  end

  // Runs one job on requester idx; sample k counts negedges after the request
  // edge (k=1 is the grant cycle). dk stays -1 if done_o never arrives.
  task automatic do_job(input int idx, input logic [7:0] seed, input logic [7:0] steps,
                        input bit chg, output logic [1:0] g, output int scnt,
                        output int dk, output logic [1:0] dv, output logic [7:0] dat,
                        output logic m, output logic [7:0] val_seen);
    @(negedge clk);
    if (idx == 0) begin seed_i[7:0] = seed; steps_i[7:0] = steps; req_i = 2'b01; end
    else          begin seed_i[15:8] = seed; steps_i[15:8] = steps; req_i = 2'b10; end
    @(negedge clk);
    g = gnt_o;
    scnt = lfsr_start_o ? 1 : 0;
    req_i = 2'b00;
    if (chg) seed_i[7:0] = 8'h55;
    dk = -1; dv = 2'b00; dat = 8'h00; m = 1'b0; val_seen = 8'h00;
    for (int k = 2; k < 600; k++) begin
      @(negedge clk);
      if (k == 2) val_seen = lfsr_val_o;
      if (lfsr_start_o) scnt++;
      if (done_o != 2'b00) begin
        dk = k; dv = done_o; dat = data_o; m = match_w;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b0; req_i = 2'b00; seed_i = '0; steps_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt_o, done_o, data_o, busy_o, lfsr_start_o, lfsr_rst_o, lfsr_val_o, match_w} !== {2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: gnt=%b done=%b data=%h busy=%b start=%b lrst=%b val=%h match=%b, required 00 00 00 0 0 1 00 0",
               gnt_o, done_o, data_o, busy_o, lfsr_start_o, lfsr_rst_o, lfsr_val_o, match_w);
    end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (lfsr_rst_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: lrst=%b busy=%b, required 0 0", lfsr_rst_o, busy_o);
    end
  endtask

  task automatic test_zero_steps;
    logic [1:0] g, dv; int scnt, dk; logic [7:0] dat, vs; logic m;
    do_job(0, 8'hAA, 8'd0, 1'b0, g, scnt, dk, dv, dat, m, vs);
    checks++;
    if (g !== 2'b01) begin fails++; $display("FAIL zero_gnt: got %b want 01", g); end
    checks++;
    if (dk !== 3 || dv !== 2'b01) begin fails++; $display("FAIL zero_done: k=%0d done=%b want k=3 done=01", dk, dv); end
    checks++;
    if (dat !== 8'hAA || scnt !== 0) begin fails++; $display("FAIL zero_data: data=%h starts=%0d want AA 0", dat, scnt); end
`ifdef LFSR_SEQ_CTRL_MATCH_EN
    checks++;
    if (m !== 1'b1) begin fails++; $display("FAIL zero_match: got %b want 1", m); end
`endif
    checks++;
    if (busy_o !== 1'b0 || gnt_o !== 2'b00) begin fails++; $display("FAIL zero_idle: busy=%b gnt=%b want 0 00", busy_o, gnt_o); end
  endtask

  task automatic test_one_step;
    logic [1:0] g, dv; int scnt, dk; logic [7:0] dat, vs; logic m;
    do_job(0, 8'hAA, 8'd1, 1'b0, g, scnt, dk, dv, dat, m, vs);
    checks++;
    if (scnt !== 1) begin fails++; $display("FAIL one_starts: got %0d want 1", scnt); end
    checks++;
    if (dk !== 4 || dv !== 2'b01) begin fails++; $display("FAIL one_done: k=%0d done=%b want k=4 done=01", dk, dv); end
    checks++;
    if (dat !== 8'h55) begin fails++; $display("FAIL one_data: got %h want 55", dat); end
  endtask

  task automatic test_long;
    logic [1:0] g, dv; int scnt, dk; logic [7:0] dat, vs, exp; logic m;
    exp = lref(8'hAA, 209);
    do_job(0, 8'hAA, 8'd209, 1'b0, g, scnt, dk, dv, dat, m, vs);
    checks++;
    if (scnt !== 209) begin fails++; $display("FAIL long_starts: got %0d want 209", scnt); end
    checks++;
    if (dk !== 212 || dv !== 2'b01) begin fails++; $display("FAIL long_done: k=%0d done=%b want k=212 done=01", dk, dv); end
    checks++;
    if (dat !== exp) begin fails++; $display("FAIL long_data: got %h want %h", dat, exp); end
`ifdef LFSR_SEQ_CTRL_MATCH_EN
    checks++;
    if (m !== (exp == 8'hAA)) begin fails++; $display("FAIL long_match: got %b want %b", m, (exp == 8'hAA)); end
`endif
  endtask

  task automatic test_seed_change;
    logic [1:0] g, dv; int scnt, dk; logic [7:0] dat, vs; logic m;
    do_job(0, 8'hAA, 8'd2, 1'b1, g, scnt, dk, dv, dat, m, vs);
    checks++;
    if (dat !== 8'hAB || dk !== 5) begin fails++; $display("FAIL seed_change_data: data=%h k=%0d want AB k=5", dat, dk); end
    checks++;
    if (vs !== 8'hAA) begin fails++; $display("FAIL seed_change_val: lfsr_val=%h want AA", vs); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] gs [4];
    logic [1:0] ds [4];
    logic [7:0] dd [4];
    int ng, nd;
    @(negedge clk); rst_i = 1'b0;
    @(negedge clk); rst_i = 1'b1;
    seed_i = {8'h80, 8'h01}; steps_i = {8'd3, 8'd3}; req_i = 2'b11;
    ng = 0; nd = 0;
    for (int k = 1; k < 200 && nd < 4; k++) begin
      @(negedge clk);
      if (gnt_o != 2'b00 && ng < 4) begin
        gs[ng] = gnt_o;
        if (ng > 0) begin
          checks++;
          if (done_o === 2'b00) begin fails++; $display("FAIL rr_coincide: grant %0d without done in same cycle", ng); end
        end
        ng++;
        if (ng == 4) req_i = 2'b00;
      end
      if (done_o != 2'b00) begin ds[nd] = done_o; dd[nd] = data_o; nd++; end
    end
    req_i = 2'b00;
    checks++;
    if (ng !== 4 || nd !== 4) begin fails++; $display("FAIL rr_count: grants=%0d dones=%0d want 4 4", ng, nd); end
    else begin
      checks++;
      if ({gs[0], gs[1], gs[2], gs[3]} !== 8'b01_10_01_10) begin
        fails++; $display("FAIL rr_order: got %b %b %b %b want 01 10 01 10", gs[0], gs[1], gs[2], gs[3]);
      end
      checks++;
      if ({ds[0], ds[1], ds[2], ds[3]} !== 8'b01_10_01_10) begin
        fails++; $display("FAIL rr_done_owner: got %b %b %b %b want 01 10 01 10", ds[0], ds[1], ds[2], ds[3]);
      end
      checks++;
      if ({dd[0], dd[1], dd[2], dd[3]} !== {8'h08, 8'h04, 8'h08, 8'h04}) begin
        fails++; $display("FAIL rr_data: got %h %h %h %h want 08 04 08 04", dd[0], dd[1], dd[2], dd[3]);
      end
    end
  endtask

  task automatic test_reset_midjob;
    logic [1:0] g, dv; int scnt, dk; logic [7:0] dat, vs; logic m;
    int seen;
    @(negedge clk);
    seed_i[7:0] = 8'hAA; steps_i[7:0] = 8'd50; req_i = 2'b01;
    @(negedge clk); req_i = 2'b00;
    repeat (10) @(negedge clk);
    checks++;
    if (lfsr_start_o !== 1'b1) begin fails++; $display("FAIL mid_running: start=%b want 1", lfsr_start_o); end
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, lfsr_rst_o, data_o, done_o, lfsr_start_o} !== {1'b0, 1'b1, 8'h00, 2'b00, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: busy=%b lrst=%b data=%h done=%b start=%b want 0 1 00 00 0",
               busy_o, lfsr_rst_o, data_o, done_o, lfsr_start_o);
    end
    rst_i = 1'b1;
    seen = 0;
    repeat (60) begin @(negedge clk); if (done_o != 2'b00 || busy_o) seen++; end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL mid_no_done: %0d active cycles after abort, want 0", seen); end
    do_job(0, 8'hAA, 8'd1, 1'b0, g, scnt, dk, dv, dat, m, vs);
    checks++;
    if (dk !== 4 || dv !== 2'b01 || dat !== 8'h55) begin
      fails++; $display("FAIL mid_recover: k=%0d done=%b data=%h want 4 01 55", dk, dv, dat);
    end
  endtask

  initial begin
    test_reset();
    test_zero_steps();
    test_one_step();
    test_long();
    test_seed_change();
    test_back_to_back();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
